// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp -- parametrised multi-read-port register file with scoreboard.
//
// Purpose:
//   ID-stage register file. NUM_RD combinational read ports, one write port,
//   optional hardwired zero register, and a per-entry pending bit used by the
//   hazard unit. A sequential clear engine zeroes one entry per cycle after
//   reset or on request; ready_o stays low until the sweep is complete.
//
// Optional feature (macro REGFILE_BYPASS_EN):
//   defined     : a read of the address being written this cycle returns
//                 wr_data_i, and its pending bit shows the post-write value.
//   not defined : reads always return the stored value and stored pending bit.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_i        synchronous active-high reset
//   clr_req_i    request an array clear (accepted only when ready)
//   rd_addr_i    packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data_o    packed read data, same packing
//   rd_pend_o    pending bit of each read port's addressed entry
//   wr_en_i      write enable
//   wr_addr_i    write address
//   wr_data_i    write data
//   pend_set_i   mark entry pend_addr_i pending
//   pend_addr_i  scoreboard set address
//   ready_o      array valid; writes and pend_set accepted only when 1
// -----------------------------------------------------------------------------
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       clr_req_i,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_pend_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       pend_set_i,
    input  logic [ADDR_W-1:0]          pend_addr_i,
    output logic                       ready_o
);

    localparam int DEPTH = 32'd1 << ADDR_W;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

    state_e              state_r;
    state_e              state_nxt_s;
    logic [ADDR_W-1:0]   clr_cnt_r;
    logic [ADDR_W-1:0]   clr_cnt_nxt_s;
    logic                ready_r;
    logic [DATA_W-1:0]   mem_r [DEPTH];
    logic [DEPTH-1:0]    pend_r;
    logic                accept_s;
    logic                wr_fire_s;
    logic                pend_fire_s;
    logic [ADDR_W-1:0]   rd_addr_s [NUM_RD];

    assign ready_o = ready_r;

    // Clear-engine next state: sweep entries in CLEAR, leave READY on request.
    always_comb begin
        state_nxt_s   = state_r;
        clr_cnt_nxt_s = clr_cnt_r;
        case (state_r)
            ST_CLEAR: begin
                clr_cnt_nxt_s = clr_cnt_r + ADDR_W'(1'b1);
                if (clr_cnt_r == {ADDR_W{1'b1}}) begin
                    state_nxt_s = ST_READY;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_READY: begin
                if (clr_req_i) begin
                    state_nxt_s   = ST_CLEAR;
                    clr_cnt_nxt_s = {ADDR_W{1'b0}};
                end else begin
                    state_nxt_s   = ST_READY;
                    clr_cnt_nxt_s = clr_cnt_r;
                end
            end
            default: begin
                state_nxt_s   = ST_CLEAR;
                clr_cnt_nxt_s = {ADDR_W{1'b0}};
            end
        endcase
    end

    // State, clear counter and ready flag registers; reset restarts the sweep.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r   <= ST_CLEAR;
            clr_cnt_r <= {ADDR_W{1'b0}};
            ready_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            clr_cnt_r <= clr_cnt_nxt_s;
            ready_r   <= (state_nxt_s == ST_READY);
        end
    end

    // Qualify write and pend_set: only in READY, dropped on a clear request,
    // and never aimed at a hardwired zero register.
    always_comb begin
        accept_s    = (state_r == ST_READY) && !clr_req_i;
        wr_fire_s   = accept_s && wr_en_i &&
                      !((ZERO_REG != 0) && (wr_addr_i == {ADDR_W{1'b0}}));
        pend_fire_s = accept_s && pend_set_i &&
                      !((ZERO_REG != 0) && (pend_addr_i == {ADDR_W{1'b0}}));
    end

    // Storage array: clear engine sweeps in CLEAR, normal writes in READY.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (state_r == ST_CLEAR) begin
                mem_r[clr_cnt_r] <= {DATA_W{1'b0}};
            end else if (wr_fire_s) begin
                mem_r[wr_addr_i] <= wr_data_i;
            end
        end
    end

    // Scoreboard bits: set wins over a same-entry write (newer producer).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_r <= {DEPTH{1'b0}};
        end else if (state_nxt_s == ST_CLEAR) begin
            pend_r <= {DEPTH{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pend_fire_s && (pend_addr_i == ADDR_W'(i))) begin
                    pend_r[i] <= 1'b1;
                end else if (wr_fire_s && (wr_addr_i == ADDR_W'(i))) begin
                    pend_r[i] <= 1'b0;
                end
            end
        end
    end

    // Unpack the per-port read addresses.
    always_comb begin
        for (int k = 0; k < NUM_RD; k++) begin
            rd_addr_s[k] = rd_addr_i[k*ADDR_W +: ADDR_W];
        end
    end

    // Combinational read ports; everything reads as zero while clearing.
    always_comb begin
        rd_data_o = {(NUM_RD*DATA_W){1'b0}};
        rd_pend_o = {NUM_RD{1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (state_r != ST_READY) begin
                rd_data_o[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_pend_o[k]                  = 1'b0;
`ifdef REGFILE_BYPASS_EN
            end else if (wr_fire_s && (rd_addr_s[k] == wr_addr_i)) begin
                // Forward the in-flight write and its post-write pending bit.
                rd_data_o[k*DATA_W +: DATA_W] = wr_data_i;
                rd_pend_o[k]                  = pend_fire_s &&
                                                (pend_addr_i == rd_addr_s[k]);
`endif
            end else if ((ZERO_REG != 0) && (rd_addr_s[k] == {ADDR_W{1'b0}})) begin
                rd_data_o[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
                rd_pend_o[k]                  = 1'b0;
            end else begin
                rd_data_o[k*DATA_W +: DATA_W] = mem_r[rd_addr_s[k]];
                rd_pend_o[k]                  = pend_r[rd_addr_s[k]];
            end
        end
    end

endmodule
